// File: rtl/bsg_mem_nr1w_pkg.sv
// Shared types, read/write collision modes and mask expansion for bsg_mem_nr1w_sync_mask.
package bsg_mem_nr1w_pkg;

  typedef enum logic [0:0] {
    eIdle  = 1'b0,
    eClear = 1'b1
  } clear_state_e;

  localparam int e_rw_read_old      = 0;
  localparam int e_rw_write_through = 1;

  // Upper bounds for the generic mask expander; callers size-cast the result down.
  localparam int max_width_gp = 256;
  localparam int max_mask_gp  = 256;

  function automatic logic [max_width_gp-1:0] expand_mask(input logic [max_mask_gp-1:0] mask,
                                                          input int gran);
    logic [max_width_gp-1:0] bits;
    bits = '0;
    for (int i = 0; i < max_width_gp; i++) bits[i] = mask[i / gran];
    return bits;
  endfunction

endpackage

// File: rtl/bsg_mem_nr1w_read_port.sv
// One synchronous read port: range check, write-collision bypass, output register.
// Parity checking is present only when BSG_MEM_NR1W_PARITY_EN is defined.
module bsg_mem_nr1w_read_port
  import bsg_mem_nr1w_pkg::*;
#(
  parameter int width_p       = 32,
  parameter int els_p         = 64,
`ifdef BSG_MEM_NR1W_PARITY_EN
  parameter int mask_gran_p   = 8,
`endif
  parameter int rw_mode_p     = e_rw_read_old,
  parameter int addr_width_lp = 6
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       mem_data_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       w_bitmask_i,
`ifdef BSG_MEM_NR1W_PARITY_EN
  input  logic [width_p/mask_gran_p-1:0] mem_par_i,
  output logic                     parity_err_o,
`endif
  output logic [width_p-1:0]       data_o
);

  localparam logic [addr_width_lp:0] els_lp = (addr_width_lp+1)'(els_p);

  logic               in_range;
  logic               hit;
  logic [width_p-1:0] merged;
  logic [width_p-1:0] data_d, data_q;

  assign in_range = {1'b0, addr_i} < els_lp;
  assign hit      = w_v_i && (addr_i == w_addr_i) && (rw_mode_p == e_rw_write_through);
  assign merged   = (mem_data_i & ~w_bitmask_i) | (w_data_i & w_bitmask_i);
  assign data_d   = !in_range ? '0 : (hit ? merged : mem_data_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  data_q <= '0;
    else if (v_i)    data_q <= data_d;
  end

  assign data_o = data_q;

`ifdef BSG_MEM_NR1W_PARITY_EN
  localparam int mask_width_lp = width_p / mask_gran_p;

  logic [mask_width_lp-1:0] slice_bad;
  logic                     err_d, err_q;

  always_comb begin
    slice_bad = '0;
    for (int k = 0; k < mask_width_lp; k++)
      slice_bad[k] = (^mem_data_i[k*mask_gran_p +: mask_gran_p]) ^ mem_par_i[k];
  end

  // Bypassed words carry freshly computed parity, so they never flag.
  assign err_d = in_range && !hit && (|slice_bad);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  err_q <= 1'b0;
    else if (v_i)    err_q <= err_d;
  end

  assign parity_err_o = err_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && v_i && !in_range) $error("read address %0d out of range", addr_i);
  end
`endif

endmodule

// File: rtl/bsg_mem_nr1w_sync_mask.sv
// N-read, 1-write synchronous RAM with per-slice write mask and a bulk clear sweep.
// Define BSG_MEM_NR1W_PARITY_EN to add per-slice even parity and parity_err_o.
module bsg_mem_nr1w_sync_mask
  import bsg_mem_nr1w_pkg::*;
#(
  parameter  int width_p       = 32,
  parameter  int els_p         = 64,
  parameter  int rd_ports_p    = 2,
  parameter  int mask_gran_p   = 8,
  parameter  int rw_mode_p     = e_rw_read_old,
  localparam int mask_width_lp = width_p / mask_gran_p,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                clear_i,
  output logic                                busy_o,
  input  logic                                w_v_i,
  output logic                                w_ready_o,
  input  logic [addr_width_lp-1:0]            w_addr_i,
  input  logic [mask_width_lp-1:0]            w_mask_i,
  input  logic [width_p-1:0]                  w_data_i,
  input  logic [rd_ports_p-1:0]               r_v_i,
  input  logic [rd_ports_p*addr_width_lp-1:0] r_addr_i,
`ifdef BSG_MEM_NR1W_PARITY_EN
  output logic [rd_ports_p-1:0]               parity_err_o,
`endif
  output logic [rd_ports_p*width_p-1:0]       r_data_o
);

  localparam logic [addr_width_lp-1:0] last_lp = addr_width_lp'(els_p - 1);
  localparam logic [addr_width_lp:0]   els_lp  = (addr_width_lp+1)'(els_p);

  clear_state_e             state_q, state_d;
  logic [addr_width_lp-1:0] cnt_q, cnt_d;

  logic                     clearing, w_in_range, w_accept, we;
  logic [addr_width_lp-1:0] we_addr;
  logic [width_p-1:0]       w_bitmask, we_bitmask, we_data;

  assign clearing   = (state_q == eClear);
  assign busy_o     = clearing;
  assign w_ready_o  = !clearing;
  assign w_in_range = {1'b0, w_addr_i} < els_lp;
  assign w_accept   = w_v_i && w_ready_o;
  assign w_bitmask  = width_p'(expand_mask(max_mask_gp'(w_mask_i), mask_gran_p));

  // The sweep owns the write port while clearing: all-ones mask, zero data.
  assign we         = clearing || (w_accept && w_in_range);
  assign we_addr    = clearing ? cnt_q : w_addr_i;
  assign we_bitmask = clearing ? '1 : w_bitmask;
  assign we_data    = clearing ? '0 : w_data_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      eIdle: begin
        if (clear_i) begin
          state_d = eClear;
          cnt_d   = '0;
        end
      end
      eClear: begin
        if (cnt_q == last_lp) state_d = eIdle;
        else                  cnt_d   = cnt_q + addr_width_lp'(1);
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [width_p-1:0] mem_q [els_p];

  always_ff @(posedge clk_i) begin
    if (we) mem_q[we_addr] <= (mem_q[we_addr] & ~we_bitmask) | (we_data & we_bitmask);
  end

`ifdef BSG_MEM_NR1W_PARITY_EN
  logic [mask_width_lp-1:0] par_q [els_p];
  logic [mask_width_lp-1:0] we_mask, we_par;

  assign we_mask = clearing ? '1 : w_mask_i;

  always_comb begin
    we_par = '0;
    for (int k = 0; k < mask_width_lp; k++)
      we_par[k] = ^we_data[k*mask_gran_p +: mask_gran_p];
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int k = 0; k < mask_width_lp; k++)
        if (we_mask[k]) par_q[we_addr][k] <= we_par[k];
    end
  end
`endif

  for (genvar p = 0; p < rd_ports_p; p++) begin : g_rd
    logic [addr_width_lp-1:0] addr;
    assign addr = r_addr_i[p*addr_width_lp +: addr_width_lp];

    bsg_mem_nr1w_read_port #(
      .width_p       (width_p),
      .els_p         (els_p),
`ifdef BSG_MEM_NR1W_PARITY_EN
      .mask_gran_p   (mask_gran_p),
`endif
      .rw_mode_p     (rw_mode_p),
      .addr_width_lp (addr_width_lp)
    ) port (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .v_i          (r_v_i[p]),
      .addr_i       (addr),
      .mem_data_i   (mem_q[addr]),
      .w_v_i        (we),
      .w_addr_i     (we_addr),
      .w_data_i     (we_data),
      .w_bitmask_i  (we_bitmask),
`ifdef BSG_MEM_NR1W_PARITY_EN
      .mem_par_i    (par_q[addr]),
      .parity_err_o (parity_err_o[p]),
`endif
      .data_o       (r_data_o[p*width_p +: width_p])
    );
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i && w_accept && !w_in_range) $error("write address %0d out of range", w_addr_i);
  end
`endif

endmodule

// File: tb/tb_bsg_mem_nr1w_sync_mask.sv
// Directed bench for bsg_mem_nr1w_sync_mask: one read-old and one write-through instance.
module tb_bsg_mem_nr1w_sync_mask;

  localparam int W = 32;
  localparam int N = 64;
  localparam int P = 2;
  localparam int G = 8;
  localparam int M = W / G;
  localparam int A = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic           w_v;
  logic [A-1:0]   w_addr;
  logic [M-1:0]   w_mask;
  logic [W-1:0]   w_data;
  logic [P-1:0]   r_v;
  logic [P*A-1:0] r_addr;
  logic           busy0, busy1, wr0, wr1;
  logic [P*W-1:0] rd0, rd1;
`ifdef BSG_MEM_NR1W_PARITY_EN
  logic [P-1:0]   perr0, perr1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_mem_nr1w_sync_mask #(.width_p(W), .els_p(N), .rd_ports_p(P), .mask_gran_p(G), .rw_mode_p(0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear), .busy_o(busy0),
    .w_v_i(w_v), .w_ready_o(wr0), .w_addr_i(w_addr), .w_mask_i(w_mask), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr),
`ifdef BSG_MEM_NR1W_PARITY_EN
    .parity_err_o(perr0),
`endif
    .r_data_o(rd0));

  bsg_mem_nr1w_sync_mask #(.width_p(W), .els_p(N), .rd_ports_p(P), .mask_gran_p(G), .rw_mode_p(1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .clear_i(clear), .busy_o(busy1),
    .w_v_i(w_v), .w_ready_o(wr1), .w_addr_i(w_addr), .w_mask_i(w_mask), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr),
`ifdef BSG_MEM_NR1W_PARITY_EN
    .parity_err_o(perr1),
`endif
    .r_data_o(rd1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d, input logic [M-1:0] m);
    w_v = 1'b1; w_addr = a; w_data = d; w_mask = m;
    tick();
    w_v = 1'b0;
  endtask

  task automatic do_read2(input logic [A-1:0] a0, input logic [A-1:0] a1);
    r_v = 2'b11; r_addr = {a1, a0};
    tick();
    r_v = 2'b00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; w_v = 1'b0; w_addr = '0; w_mask = '0; w_data = '0;
    r_v = '0; r_addr = '0;
    #12;
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0", busy0, busy1); end
    checks++; if (wr0 !== 1'b1 || wr1 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b exp 1", wr0, wr1); end
    checks++; if (rd0 !== '0 || rd1 !== '0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", rd0, rd1); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (rd0 !== '0) begin errors++; $display("FAIL idle_hold got %h exp 0", rd0); end
  endtask

  task automatic test_mask_write();
    do_write(6'd5, 32'hAABBCCDD, 4'b1111);
    do_write(6'd5, 32'h11223344, 4'b0101);
    do_read2(6'd5, 6'd5);
    checks++; if (rd0 !== {32'hAA22CC44, 32'hAA22CC44}) begin errors++; $display("FAIL mask_merge got %h exp aa22cc44 x2", rd0); end
    checks++; if (rd1 !== {32'hAA22CC44, 32'hAA22CC44}) begin errors++; $display("FAIL mask_merge_wt got %h exp aa22cc44 x2", rd1); end
    do_write(6'd5, 32'h00000000, 4'b0000);
    do_read2(6'd5, 6'd5);
    checks++; if (rd0[W-1:0] !== 32'hAA22CC44) begin errors++; $display("FAIL mask_noop got %h exp aa22cc44", rd0[W-1:0]); end
  endtask

  task automatic test_collision();
    do_write(6'd3, 32'h0, 4'b1111);
    w_v = 1'b1; w_addr = 6'd3; w_data = 32'hFFFFFFFF; w_mask = 4'b1111;
    r_v = 2'b11; r_addr = {6'd5, 6'd3};
    tick();
    w_v = 1'b0; r_v = 2'b00;
    checks++; if (rd0[W-1:0] !== 32'h0) begin errors++; $display("FAIL coll_old got %h exp 0", rd0[W-1:0]); end
    checks++; if (rd1[W-1:0] !== 32'hFFFFFFFF) begin errors++; $display("FAIL coll_wt got %h exp ffffffff", rd1[W-1:0]); end
    checks++; if (rd0[2*W-1:W] !== 32'hAA22CC44 || rd1[2*W-1:W] !== 32'hAA22CC44) begin errors++; $display("FAIL coll_other got %h/%h exp aa22cc44", rd0[2*W-1:W], rd1[2*W-1:W]); end
    do_read2(6'd3, 6'd3);
    checks++; if (rd0 !== {2{32'hFFFFFFFF}} || rd1 !== {2{32'hFFFFFFFF}}) begin errors++; $display("FAIL coll_after got %h/%h exp ffffffff", rd0, rd1); end
    w_v = 1'b1; w_addr = 6'd3; w_data = 32'h12345678; w_mask = 4'b0011;
    r_v = 2'b11; r_addr = {6'd3, 6'd3};
    tick();
    w_v = 1'b0; r_v = 2'b00;
    checks++; if (rd0 !== {2{32'hFFFFFFFF}}) begin errors++; $display("FAIL coll_part_old got %h exp ffffffff x2", rd0); end
    checks++; if (rd1 !== {2{32'hFFFF5678}}) begin errors++; $display("FAIL coll_part_wt got %h exp ffff5678 x2", rd1); end
    do_read2(6'd3, 6'd3);
    checks++; if (rd0 !== {2{32'hFFFF5678}}) begin errors++; $display("FAIL coll_part_after got %h exp ffff5678 x2", rd0); end
  endtask

  task automatic test_hold();
    r_v = 2'b01; r_addr = {6'd5, 6'd5};
    tick();
    r_v = 2'b00;
    checks++; if (rd0[W-1:0] !== 32'hAA22CC44) begin errors++; $display("FAIL hold_p0 got %h exp aa22cc44", rd0[W-1:0]); end
    checks++; if (rd0[2*W-1:W] !== 32'hFFFF5678) begin errors++; $display("FAIL hold_p1 got %h exp ffff5678", rd0[2*W-1:W]); end
  endtask

`ifdef BSG_MEM_NR1W_PARITY_EN
  task automatic test_parity();
    do_write(6'd2, 32'h00000001, 4'b1111);
    do_read2(6'd2, 6'd5);
    checks++; if (perr0 !== 2'b00) begin errors++; $display("FAIL par_clean got %b exp 00", perr0); end
    dut0.mem_q[2][4] = ~dut0.mem_q[2][4];
    do_read2(6'd2, 6'd5);
    checks++; if (perr0 !== 2'b01) begin errors++; $display("FAIL par_flip got %b exp 01", perr0); end
    tick();
    checks++; if (perr0 !== 2'b01) begin errors++; $display("FAIL par_hold got %b exp 01", perr0); end
    do_read2(6'd5, 6'd5);
    checks++; if (perr0 !== 2'b00) begin errors++; $display("FAIL par_next got %b exp 00", perr0); end
  endtask
`endif

  task automatic test_clear();
    int busy_cycles;
    int ready_bad;
    logic [W-1:0] exp_lo;
    for (int i = 0; i < N; i++) do_write(A'(i), 32'hC0DE0000 | i, 4'b1111);
    do_read2(6'd0, 6'd63);
    checks++; if (rd0 !== {32'hC0DE003F, 32'hC0DE0000}) begin errors++; $display("FAIL fill got %h exp c0de003fc0de0000", rd0); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    w_v = 1'b1; w_addr = 6'd7; w_data = 32'h5A5A5A5A; w_mask = 4'b1111;
    busy_cycles = 0; ready_bad = 0;
    for (int i = 0; i < 200 && busy0 === 1'b1; i++) begin
      busy_cycles++;
      if (wr0 !== 1'b0 || busy1 !== 1'b1) ready_bad++;
      tick();
    end
    checks++; if (busy_cycles != N) begin errors++; $display("FAIL clear_len got %0d exp %0d", busy_cycles, N); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL clear_ready got %0d bad cycles exp 0", ready_bad); end
    checks++; if (wr0 !== 1'b1) begin errors++; $display("FAIL clear_done_ready got %b exp 1", wr0); end
    tick();
    w_v = 1'b0;
    for (int i = 0; i < N / 2; i++) begin
      do_read2(A'(i), A'(i + N / 2));
      exp_lo = (i == 7) ? 32'h5A5A5A5A : 32'h0;
      checks++;
      if (rd0 !== {32'h0, exp_lo}) begin errors++; $display("FAIL clear_word %0d got %h exp %h", i, rd0, {32'h0, exp_lo}); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 12; i++) do_write(A'(i), 32'hDEAD0000 | i, 4'b1111);
    clear = 1'b1;
    w_v = 1'b1; w_addr = 6'd2; w_data = 32'h77777777; w_mask = 4'b1111;
    tick();
    clear = 1'b0; w_v = 1'b0;
    repeat (10) tick();
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy0); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy0 !== 1'b0 || wr0 !== 1'b1) begin errors++; $display("FAIL mid_reset got busy %b ready %b exp 0/1", busy0, wr0); end
    checks++; if (rd0 !== '0) begin errors++; $display("FAIL mid_rdata got %h exp 0", rd0); end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      do_read2(A'(i), 6'd2);
      checks++;
      if (rd0 !== '0) begin errors++; $display("FAIL mid_word %0d got %h exp 0", i, rd0); end
    end
  endtask

  initial begin
    test_reset();
    test_mask_write();
    test_collision();
    test_hold();
`ifdef BSG_MEM_NR1W_PARITY_EN
    test_parity();
`endif
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_mem_nr1w_sync_mask.md
Name: bsg_mem_Nr1w_sync_mask

Overview:
- Synchronous-read RAM: one write port with a per-slice write mask, rd_ports_p independent synchronous read ports.
- Configurable read-during-write behaviour per port.
- Built-in clear engine zeroes the whole array without software loops.
- Used for register files, tag arrays and scratchpads that need several reads per cycle or bulk invalidation.

Parameters:
- width_p, 32: data word width in bits.
- els_p, 64: number of words (≥2).
- rd_ports_p, 2: number of read ports (1..4).
- mask_gran_p, 8: bits per write-mask bit; width_p % mask_gran_p == 0.
- rw_mode_p, 0: same-address read/write in one cycle. 0 = read-old (pre-write contents); 1 = write-through (post-write merged word).
- mask_width_lp, width_p/mask_gran_p: derived.
- addr_width_lp, clog2(els_p), min 1: derived.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- clear_i  in  1  one-cycle pulse; starts the clear sweep.
- busy_o  out  1  clear sweep in progress.
- w_v_i  in  1  write valid.
- w_ready_o  out  1  write accepted when w_v_i & w_ready_o.
- w_addr_i  in  addr_width_lp  write address.
- w_mask_i  in  mask_width_lp  bit k enables data bits [k*mask_gran_p +: mask_gran_p].
- w_data_i  in  width_p  write data.
- r_v_i  in  rd_ports_p  per-port read valid.
- r_addr_i  in  rd_ports_p*addr_width_lp  packed read addresses; port p at slice p.
- r_data_o  out  rd_ports_p*width_p  packed read data.

Behaviour:
- Reset (reset_n_i=0, async): r_data_o=0, busy_o=0, w_ready_o=1, FSM=IDLE. Array contents are not reset.
- Read latency is 1 cycle. r_v_i[p] at edge t puts mem[r_addr_p] on r_data_o[p] after t. If r_v_i[p]=0, r_data_o[p] holds its previous value.
- Write: when w_v_i & w_ready_o at edge t, masked slices are updated. Unmasked slices keep old bits. w_mask_i=0 is a legal no-op.
- Same-address collision (read and write to the same address in one cycle):
  - rw_mode_p=0: port returns the old word.
  - rw_mode_p=1: port returns the merged word, (old & ~expanded_mask) | (w_data_i & expanded_mask).
  - Applies independently to every port.
- Multiple read ports may use the same address; all get the same data.
- Out-of-range addresses (≥ els_p, non-power-of-2 depth): write is dropped; read returns 0. Simulation $error on either.
- FSM IDLE→CLEAR:
  - Transition on clear_i in IDLE. Counter set to 0, busy_o=1, w_ready_o=0.
  - CLEAR writes 0 to mem[counter] each cycle and increments the counter.
  - When counter==els_p-1, that final write completes, then IDLE. Sweep is exactly els_p cycles.
  - clear_i during CLEAR is ignored (no restart).
- Reads during CLEAR are allowed. Same-address result follows rw_mode_p with an all-ones mask and zero data. Other addresses return current contents.
- External writes are not accepted during CLEAR: w_ready_o=0; the requester holds w_v_i.
- clear_i and w_v_i in the same IDLE cycle: the write is accepted this cycle, the sweep starts next cycle, so the written address is later zeroed.
- Reset mid-sweep: FSM returns to IDLE, busy_o=0, array partially cleared, contents undefined beyond the counter.

Optional Feature:
- Macro: BSG_MEM_NR1W_PARITY_EN.
- Defined:
  - One even-parity bit is stored per mask slice and written with that slice.
  - Clear writes parity 0.
  - Output port parity_err_o [rd_ports_p] is registered alongside r_data_o: high for one read when any slice of the returned word fails parity.
  - Reset value 0. Holds with the data when r_v_i=0.
  - Write-through bypass data uses freshly computed parity, so it never flags.
- Undefined: no parity storage, no parity_err_o port.

Decomposition:
- Package bsg_mem_nr1w_pkg holds:
  - clear FSM state enum {eIdle, eClear};
  - rw-mode constants e_rw_read_old=0, e_rw_write_through=1;
  - function expanding a mask to a bit mask given mask_gran_p.
- Sub-module bsg_mem_nr1w_read_port: one read port's address check, bypass mux, output register and optional parity check. Instantiated rd_ports_p times in a generate loop.

Test Plan:
- Reset then read addr 0 on both ports, no writes → r_data_o=0 before the first read; reading never-cleared memory yields X only after the first valid read.
- Write 0xAABBCCDD mask 4'b1111 to addr 5; next cycle write 0x11223344 mask 4'b0101 to addr 5; read addr 5 → 0xAA22CC44 one cycle later.
- rw_mode_p=0, mem[3]=0x0; same cycle write 0xFFFFFFFF full mask to 3 and read 3 on port 0 → port 0 returns 0x0; read again → 0xFFFFFFFF. Repeat with rw_mode_p=1 → first read returns 0xFFFFFFFF.
- Fill all 64 words, pulse clear_i → busy_o high exactly 64 cycles, w_ready_o=0 throughout; a w_v_i held during the sweep commits on the first cycle after busy_o falls; every other word reads 0.
- Pulse clear_i, deassert reset_n_i at sweep cycle 10 → busy_o=0 immediately; mem[0..9] read 0; w_ready_o=1.
- With BSG_MEM_NR1W_PARITY_EN: write 0x01 to addr 2, force-flip a stored data bit via hierarchy, read 2 → parity_err_o[0]=1 for that read only; reading a clean word → 0.
